// File: rtl/irq_arbiter.sv
// Interrupt arbiter: gates level-sensitive sources, picks the highest-priority pending one
// above threshold, and serialises service through a claim/complete handshake on a register bus.
module irq_arbiter #(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic [2:0]         addr,
   input  logic [31:0]        wdata,
   input  logic               write_en,
   input  logic               read_en,
   output logic [31:0]        rdata,
   output logic               intr_ext
);

   localparam int PRIO_BITS = NUM_SRC * PRIO_W;

   localparam logic [2:0] A_ENABLE   = 3'd0;
   localparam logic [2:0] A_PENDING  = 3'd1;
   localparam logic [2:0] A_PRIORITY = 3'd2;
   localparam logic [2:0] A_THRESH   = 3'd3;
   localparam logic [2:0] A_CLAIM    = 3'd4;
   localparam logic [2:0] A_STATUS   = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_NOTIFY  = 2'd1,
      ST_CLAIMED = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [NUM_SRC-1:0]   enable_q, enable_d;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [PRIO_BITS-1:0] prio_q, prio_d;
   logic [PRIO_W-1:0]    thresh_q, thresh_d;
   logic [7:0]           in_service_q, in_service_d;
   logic                 entry_q, entry_d;
   logic                 intr_q;

   logic [PRIO_W-1:0]    src_prio [NUM_SRC];
   logic                 cand_found;
   logic [3:0]           cand_idx;
   logic [PRIO_W-1:0]    cand_prio;
   logic [7:0]           cand_id;
   logic [NUM_SRC-1:0]   cand_mask;
   logic [NUM_SRC-1:0]   in_service_mask;

   logic                 wr_enable, wr_prio, wr_thresh;
   logic                 claim_req, complete_req, claim_fire;
   logic                 unused_bits;

   // Bus decode. A simultaneous write suppresses the claim side effect of a read.
   assign wr_enable    = write_en && (addr == A_ENABLE);
   assign wr_prio      = write_en && (addr == A_PRIORITY);
   assign wr_thresh    = write_en && (addr == A_THRESH);
   assign claim_req    = read_en && !write_en && (addr == A_CLAIM);
   assign complete_req = write_en && (addr == A_CLAIM) && (wdata[7:0] == in_service_q);
   assign unused_bits  = ^wdata;

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_prio[i] = prio_q[i*PRIO_W +: PRIO_W];
      end
   end

   // Strict compare while scanning upward keeps the lowest index on a priority tie.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = 4'd0;
      cand_prio  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pending_q[i] && enable_q[i] && (src_prio[i] > thresh_q)) begin
            if (!cand_found || (src_prio[i] > cand_prio)) begin
               cand_found = 1'b1;
               cand_idx   = 4'(i);
               cand_prio  = src_prio[i];
            end
         end
      end
      cand_id = cand_found ? ({4'd0, cand_idx} + 8'd1) : 8'd0;
   end

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         cand_mask[i]       = cand_found && (cand_idx == 4'(i));
         in_service_mask[i] = (in_service_q == 8'(i + 1));
      end
   end

   always_comb begin
      state_d      = state_q;
      in_service_d = in_service_q;
      entry_d      = 1'b0;
      claim_fire   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cand_found) begin
               state_d = ST_NOTIFY;
               entry_d = 1'b1;
            end
         end
         ST_NOTIFY: begin
            if (!cand_found) begin
               state_d = ST_IDLE;
            end else if (claim_req) begin
               state_d      = ST_CLAIMED;
               in_service_d = cand_id;
               claim_fire   = 1'b1;
            end
         end
         ST_CLAIMED: begin
            if (complete_req) begin
               state_d      = ST_IDLE;
               in_service_d = 8'd0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            in_service_d = 8'd0;
         end
      endcase
   end

   // Gateway: a source in service cannot re-pend; the claim clear overrides a same-cycle set.
   always_comb begin
      pending_d = (pending_q | (src_irq & ~in_service_mask))
                & ~(claim_fire ? cand_mask : {NUM_SRC{1'b0}});
      enable_d  = wr_enable ? wdata[NUM_SRC-1:0]   : enable_q;
      prio_d    = wr_prio   ? wdata[PRIO_BITS-1:0] : prio_q;
      thresh_d  = wr_thresh ? wdata[PRIO_W-1:0]    : thresh_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         enable_q     <= '0;
         pending_q    <= '0;
         prio_q       <= '0;
         thresh_q     <= '0;
         in_service_q <= 8'd0;
         entry_q      <= 1'b0;
         intr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         enable_q     <= enable_d;
         pending_q    <= pending_d;
         prio_q       <= prio_d;
         thresh_q     <= thresh_d;
         in_service_q <= in_service_d;
         entry_q      <= entry_d;
         intr_q       <= entry_q;
      end
   end

   assign intr_ext = intr_q;

   always_comb begin
      rdata = 32'd0;
      case (addr)
         A_ENABLE:   rdata[NUM_SRC-1:0]   = enable_q;
         A_PENDING:  rdata[NUM_SRC-1:0]   = pending_q;
         A_PRIORITY: rdata[PRIO_BITS-1:0] = prio_q;
         A_THRESH:   rdata[PRIO_W-1:0]    = thresh_q;
         A_CLAIM:    rdata[7:0]           = (state_q == ST_NOTIFY) ? cand_id : 8'd0;
         A_STATUS:   rdata[9:0]           = {in_service_q, state_q};
         default:    rdata                = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: each scenario task drives the bus and checks its own results,
// with intr_ext pulses tallied by a negedge monitor.
module tb_irq_arbiter;

   logic        clk;
   logic        reset;
   logic [7:0]  src_irq;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic        write_en;
   logic        read_en;
   logic [31:0] rdata;
   logic        intr_ext;

   int checks;
   int failures;
   int pulse_cnt;

   irq_arbiter #(.NUM_SRC(8), .PRIO_W(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .src_irq  (src_irq),
      .addr     (addr),
      .wdata    (wdata),
      .write_en (write_en),
      .read_en  (read_en),
      .rdata    (rdata),
      .intr_ext (intr_ext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (intr_ext === 1'b1) pulse_cnt++;

   // Drivers start on a negedge and release strobes just after the following posedge.
   task automatic do_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wdata = d; write_en = 1'b1;
      @(posedge clk); #1;
      write_en = 1'b0;
   endtask

   task automatic do_claim(output logic [31:0] d);
      @(negedge clk);
      addr = 3'd4; read_en = 1'b1;
      #1 d = rdata;
      @(posedge clk); #1;
      read_en = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      addr = a;
      #1 d = rdata;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_reg%0d: got %h expected %h", a, d, 32'h0); end
      end
      checks++; if (intr_ext !== 1'b0) begin failures++; $display("FAIL reset_intr: got %b expected 0", intr_ext); end
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic test_single();
      logic [31:0] d;
      int base;
      do_write(3'd0, 32'h1);
      do_write(3'd2, 32'h1);
      base = pulse_cnt;
      @(negedge clk) src_irq = 8'h01;
      @(negedge clk); addr = 3'd1; #1;
      checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL single_pending: got %h expected %h", rdata, 32'h1); end
      checks++; if (intr_ext !== 1'b0) begin failures++; $display("FAIL single_intr_c1: got %b expected 0", intr_ext); end
      @(negedge clk); addr = 3'd5; #1;
      checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL single_notify: got %h expected %h", rdata, 32'h1); end
      checks++; if (intr_ext !== 1'b0) begin failures++; $display("FAIL single_intr_c2: got %b expected 0", intr_ext); end
      @(negedge clk); #1;
      checks++; if (intr_ext !== 1'b1) begin failures++; $display("FAIL single_intr_c3: got %b expected 1", intr_ext); end
      @(negedge clk); #1;
      checks++; if (intr_ext !== 1'b0) begin failures++; $display("FAIL single_intr_c4: got %b expected 0", intr_ext); end
      do_claim(d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL single_claim: got %h expected %h", d, 32'h1); end
      rd(3'd1, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL single_pending_clr: got %h expected %h", d, 32'h0); end
      rd(3'd5, d);
      checks++; if (d !== 32'h6) begin failures++; $display("FAIL single_status: got %h expected %h", d, 32'h6); end
      checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL single_pulses: got %0d expected 1", pulse_cnt - base); end
      src_irq = 8'h00;
      do_write(3'd4, 32'h1);
      rd(3'd5, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL single_complete: got %h expected %h", d, 32'h0); end
   endtask

   task automatic test_priority();
      logic [31:0] d;
      int base;
      do_write(3'd0, 32'hFF);
      do_write(3'd2, 32'hC10);
      rd(3'd0, d);
      checks++; if (d !== 32'hFF) begin failures++; $display("FAIL prio_enable_rb: got %h expected %h", d, 32'hFF); end
      rd(3'd2, d);
      checks++; if (d !== 32'hC10) begin failures++; $display("FAIL prio_prio_rb: got %h expected %h", d, 32'hC10); end
      rd(3'd7, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL prio_unmapped: got %h expected %h", d, 32'h0); end
      base = pulse_cnt;
      @(negedge clk) src_irq = 8'h24;
      @(negedge clk) src_irq = 8'h00;
      repeat (4) @(negedge clk);
      checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL prio_pulse1: got %0d expected 1", pulse_cnt - base); end
      do_claim(d);
      checks++; if (d !== 32'h6) begin failures++; $display("FAIL prio_claim_hi: got %h expected %h", d, 32'h6); end
      do_write(3'd4, 32'h6);
      repeat (4) @(negedge clk);
      checks++; if (pulse_cnt - base !== 2) begin failures++; $display("FAIL prio_pulse2: got %0d expected 2", pulse_cnt - base); end
      do_claim(d);
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL prio_claim_lo: got %h expected %h", d, 32'h3); end
      rd(3'd5, d);
      checks++; if (d !== 32'hE) begin failures++; $display("FAIL prio_status: got %h expected %h", d, 32'hE); end
   endtask

   task automatic test_complete_mismatch();
      logic [31:0] d;
      do_write(3'd4, 32'h5);
      rd(3'd5, d);
      checks++; if (d !== 32'hE) begin failures++; $display("FAIL mism_status: got %h expected %h", d, 32'hE); end
      src_irq = 8'h04;
      repeat (3) @(posedge clk);
      rd(3'd1, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL mism_no_repend: got %h expected %h", d, 32'h0); end
      do_write(3'd4, 32'h3);
      repeat (2) @(posedge clk);
      rd(3'd1, d);
      checks++; if (d !== 32'h4) begin failures++; $display("FAIL mism_repend: got %h expected %h", d, 32'h4); end
      src_irq = 8'h00;
      repeat (4) @(negedge clk);
      do_claim(d);
      checks++; if (d !== 32'h3) begin failures++; $display("FAIL mism_reclaim: got %h expected %h", d, 32'h3); end
      do_write(3'd4, 32'h3);
      rd(3'd5, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL mism_idle: got %h expected %h", d, 32'h0); end
   endtask

   task automatic test_tie_threshold();
      logic [31:0] d;
      int base;
      do_write(3'd2, 32'h208);
      base = pulse_cnt;
      @(negedge clk) src_irq = 8'h12;
      @(negedge clk) src_irq = 8'h00;
      repeat (4) @(negedge clk);
      do_claim(d);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL tie_claim: got %h expected %h", d, 32'h2); end
      do_write(3'd3, 32'h2);
      do_write(3'd4, 32'h2);
      repeat (3) @(posedge clk);
      rd(3'd5, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL thr_state: got %h expected %h", d, 32'h0); end
      do_claim(d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL thr_claim: got %h expected %h", d, 32'h0); end
      rd(3'd1, d);
      checks++; if (d !== 32'h10) begin failures++; $display("FAIL thr_pending: got %h expected %h", d, 32'h10); end
      checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL thr_pulses: got %0d expected 1", pulse_cnt - base); end
      do_write(3'd3, 32'h0);
      repeat (4) @(negedge clk);
      do_claim(d);
      checks++; if (d !== 32'h5) begin failures++; $display("FAIL thr_claim_after: got %h expected %h", d, 32'h5); end
      checks++; if (pulse_cnt - base !== 2) begin failures++; $display("FAIL thr_pulses2: got %0d expected 2", pulse_cnt - base); end
      do_write(3'd4, 32'h5);
   endtask

   task automatic test_notify_disable();
      logic [31:0] d;
      int base;
      base = pulse_cnt;
      @(negedge clk) src_irq = 8'h02;
      @(negedge clk) src_irq = 8'h00;
      repeat (4) @(negedge clk);
      rd(3'd5, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL nd_notify: got %h expected %h", d, 32'h1); end
      @(negedge clk);
      addr = 3'd4; wdata = 32'h0; write_en = 1'b1; read_en = 1'b1;
      @(posedge clk); #1;
      write_en = 1'b0; read_en = 1'b0;
      rd(3'd5, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL nd_wr_rd_state: got %h expected %h", d, 32'h1); end
      rd(3'd1, d);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL nd_wr_rd_pending: got %h expected %h", d, 32'h2); end
      do_write(3'd0, 32'h0);
      @(posedge clk);
      rd(3'd5, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL nd_idle: got %h expected %h", d, 32'h0); end
      do_claim(d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL nd_claim_idle: got %h expected %h", d, 32'h0); end
      repeat (4) @(negedge clk);
      checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL nd_no_pulse: got %0d expected 1", pulse_cnt - base); end
      rd(3'd1, d);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL nd_pending_kept: got %h expected %h", d, 32'h2); end
      do_write(3'd0, 32'hFF);
      repeat (4) @(negedge clk);
      checks++; if (pulse_cnt - base !== 2) begin failures++; $display("FAIL nd_new_pulse: got %0d expected 2", pulse_cnt - base); end
      do_claim(d);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL nd_claim: got %h expected %h", d, 32'h2); end
      do_write(3'd4, 32'h2);
   endtask

   task automatic test_reset_mid_service();
      logic [31:0] d;
      int base;
      do_write(3'd2, 32'h1);
      do_write(3'd0, 32'h1);
      src_irq = 8'h01;
      repeat (5) @(negedge clk);
      do_claim(d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL rst_claim: got %h expected %h", d, 32'h1); end
      rd(3'd5, d);
      checks++; if (d !== 32'h6) begin failures++; $display("FAIL rst_status_pre: got %h expected %h", d, 32'h6); end
      base = pulse_cnt;
      @(negedge clk) reset = 1'b1;
      for (int a = 0; a < 6; a++) begin
         rd(3'(a), d);
         checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_reg%0d: got %h expected %h", a, d, 32'h0); end
         checks++; if (intr_ext !== 1'b0) begin failures++; $display("FAIL rst_intr%0d: got %b expected 0", a, intr_ext); end
      end
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      rd(3'd1, d);
      checks++; if (d !== 32'h1) begin failures++; $display("FAIL rst_repend: got %h expected %h", d, 32'h1); end
      rd(3'd5, d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_state_idle: got %h expected %h", d, 32'h0); end
      repeat (4) @(negedge clk);
      checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL rst_no_pulse: got %0d expected 0", pulse_cnt - base); end
      src_irq = 8'h00;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      pulse_cnt = 0;
      reset     = 1'b1;
      src_irq   = 8'h00;
      addr      = 3'd0;
      wdata     = 32'h0;
      write_en  = 1'b0;
      read_en   = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_complete_mismatch();
      test_tie_threshold();
      test_notify_disable();
      test_reset_mid_service();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
